// File: rtl/seven_seg_pkg.sv
// Shared types for the seven-segment display path.
// Covers the digit values, digit indices and per-digit enable masks.
package seven_seg_pkg;

    localparam int NUM_DIGITS = 8;

    typedef logic [3:0] digit_t;
    typedef logic [2:0] digit_sel_t;
    typedef logic [7:0] digit_mask_t;

endpackage

// File: rtl/seven_seg_next_sel.sv
// Circular first-set search: the next enabled digit after sel, wrapping 7 -> 0.
// Returns sel itself when no other digit is enabled.
module seven_seg_next_sel
    import seven_seg_pkg::*;
(
    input  digit_sel_t  sel,
    input  digit_mask_t digit_en,
    output digit_sel_t  next_sel
);

    digit_sel_t cand;

    // Walk from the farthest candidate to the nearest so the nearest hit wins last.
    always_comb begin
        next_sel = sel;
        cand     = sel;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            cand = sel + digit_sel_t'(i);
            if (digit_en[cand]) begin
                next_sel = cand;
            end
        end
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed refresh stage: stores eight hex digits and rotates through
// the enabled ones, presenting a consistent (num, sel, blank) triple each cycle.
module seven_segment_scanner
    import seven_seg_pkg::*;
#(
    parameter int DIV_COUNT    = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  digit_sel_t  wr_addr,
    input  digit_t      wr_data,
    input  digit_mask_t digit_en,
    output digit_t      num,
    output digit_sel_t  sel,
    output logic        blank,
    output logic        slot_tick
);

    localparam int             CNT_W     = $clog2(DIV_COUNT);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIV_COUNT - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    digit_sel_t       sel_q, sel_d;
    digit_t           num_q, num_d;
    logic             blank_q, blank_d;
    logic             tick_q, tick_d;
    digit_t           mem_q [NUM_DIGITS];
    digit_t           mem_d [NUM_DIGITS];

    logic       wrap;
    digit_sel_t scan_sel;

    seven_seg_next_sel u_next_sel (
        .sel      (sel_q),
        .digit_en (digit_en),
        .next_sel (scan_sel)
    );

    // num reads the post-write memory image, so a write to the digit about to be
    // shown is visible on the same edge it is stored.
    always_comb begin
        wrap   = (cnt_q == CNT_MAX);
        cnt_d  = wrap ? '0 : cnt_q + 1'b1;
        tick_d = wrap;
        sel_d  = wrap ? scan_sel : sel_q;

        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end

        num_d   = mem_d[sel_d];
        blank_d = (cnt_d < BLANK_LIM) || !digit_en[sel_d] || (digit_en == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            sel_q   <= '0;
            num_q   <= '0;
            blank_q <= 1'b1;
            tick_q  <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            num_q   <= num_d;
            blank_q <= blank_d;
            tick_q  <= tick_d;
            mem_q   <= mem_d;
        end
    end

    assign num       = num_q;
    assign sel       = sel_q;
    assign blank     = blank_q;
    assign slot_tick = tick_q;

endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
- Time-multiplexing refresh stage directly upstream of the seven_segment decoder.
- Holds eight 4-bit digit values and rotates through the enabled digits at a programmable slot rate.
- Each slot presents one (num, sel) pair to the decoder, plus a blank flag.
- Top level forces all anodes off while blank=1: anode_out = anode | {8{blank}}.

Parameters:
- DIV_COUNT, 100000: clock cycles per digit slot; legal range >= 2.
- BLANK_CYCLES, 16: anti-ghosting guard; cycles at the start of each slot with blank forced high; legal range 0 .. DIV_COUNT-1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write strobe for digit storage.
- wr_addr  input  3  digit index to write.
- wr_data  input  4  hex value to store.
- digit_en  input  8  per-digit enable; bit i=1 means digit i participates in the scan.
- num  output  4  registered hex value for the current digit; to decoder num.
- sel  output  3  registered current digit index; to decoder sel.
- blank  output  1  registered; 1 = anodes must be off.
- slot_tick  output  1  registered one-cycle pulse on each slot boundary.

Behaviour:
- Reset (async assert, sync release):
  - digit memory all 0, prescaler 0, sel=0, num=0, blank=1, slot_tick=0.
  - Any operation in progress is abandoned; there is no partial-slot carry-over.
- Prescaler:
  - Counts 0..DIV_COUNT-1, then wraps to 0.
  - On the edge where the count wraps, slot_tick=1 for exactly that cycle.
- Slot advance (same edge as the wrap):
  - sel <= next enabled index, searched circularly from sel+1 (7 wraps to 0).
  - Index order is ascending.
  - If only the current digit is enabled, sel is unchanged.
  - If digit_en==0, sel is unchanged.
- num:
  - Updated every cycle: num <= mem[sel_next].
  - Write bypass: if wr_en and wr_addr==sel_next, num <= wr_data on the same edge that mem is written.
  - A write to the displayed digit is therefore visible on num one edge after wr_en is sampled, with no stale cycle.
  - A write to a non-displayed digit appears when that digit is next scanned.
- Write:
  - mem[wr_addr] <= wr_data when wr_en=1.
  - Writes are allowed in any cycle, including a slot-boundary cycle.
- blank is registered, computed from next-state values. blank=1 when any of:
  - prescaler_next < BLANK_CYCLES;
  - digit_en[sel_next]==0;
  - digit_en==0.
  - Otherwise blank=0.
- digit_en changes mid-slot:
  - If the current digit becomes disabled, blank=1 from the next edge.
  - sel still moves only at the next slot boundary.
- Latency: num, sel and blank change on the same edge, so the decoder always sees a consistent triple.
- slot_tick and sel change on the same edge.

Decomposition:
- Package seven_seg_pkg:
  - NUM_DIGITS=8
  - typedef logic[3:0] digit_t
  - typedef logic[2:0] digit_sel_t
  - typedef logic[7:0] digit_mask_t
- One combinational sub-module, seven_seg_next_sel:
  - inputs: current sel, digit_en; output: next enabled index.
  - Implements the circular first-set search and returns the current sel when no other enabled digit exists.
- Top-level integration wrapper (scanner + decoder + anode gating) is outside this block.

Test Plan (bench uses DIV_COUNT=4, BLANK_CYCLES=1, digit_en=8'hFF unless stated):
- Reset mid-operation:
  - Stimulus: run 10 cycles, assert rst_n=0 mid-slot.
  - Required: num=0, sel=0, blank=1, slot_tick=0 immediately, without a clock edge. After release, the first slot_tick occurs 4 cycles later.
- Full scan:
  - Stimulus: write mem[i]=i+8 for i=0..7.
  - Required: sel steps 0,1,..,7,0 with one slot_tick per 4 cycles; num=8+sel each slot. blank=1 for the first cycle of each slot and 0 for the remaining 3.
- Skip/wrap:
  - Stimulus: digit_en=8'b1000_0101.
  - Required: sel sequence 0,2,7,0,2. With digit_en=8'b0001_0000, sel stays 4 and blank follows only the guard pattern.
- All disabled:
  - Stimulus: digit_en=8'h00.
  - Required: blank=1 continuously, sel frozen, slot_tick still pulses every 4 cycles.
- Write bypass:
  - Stimulus: while sel=3, write wr_addr=3, wr_data=4'hA.
  - Required: num=4'hA on the next edge. In the same cycle as a slot boundary from 3 to 4, write wr_addr=4, wr_data=4'hF; required: num=4'hF with sel=4 on that edge.
- Mid-slot disable:
  - Stimulus: while sel=5 and blank=0, clear digit_en[5].
  - Required: blank=1 next edge, sel stays 5 until slot_tick, then advances to 6.
- Bench checks num, sel and blank against a reference model every cycle, and feeds num and sel into the decoder to confirm anode = ~(1<<sel) whenever blank=0.
